// File: rtl/ascon_pkg.sv
// Shared definitions for the serial Ascon wrapper stages: tag length,
// the deserializer state encoding and a constant-foldable clog2.
package ascon_pkg;

    localparam int ASCON_TAG_BITS = 128;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ascon_result_deserializer.sv
// Reassembles the LSB-first serial payload/tag lines of the Ascon wrapper into
// buffers and drains them as W-bit words (payload first, then tag) over valid/ready.
module ascon_result_deserializer
    import ascon_pkg::*;
#(
    parameter int Y = 200,
    parameter int T = ASCON_TAG_BITS,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ready_si,
    input  logic         data_si,
    input  logic         tag_si,
    input  logic         clear,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_is_tag,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    localparam int MAXB = (Y > T) ? Y : T;
    localparam int ND   = (Y + W - 1) / W;
    localparam int NT   = (T + W - 1) / W;
    localparam int NW   = ND + NT;
    localparam int BCW  = clog2(MAXB + 1);
    localparam int WCW  = clog2(NW + 1);
    localparam int DIW  = (clog2(Y) > 0) ? clog2(Y) : 1;
    localparam int TIW  = (clog2(T) > 0) ? clog2(T) : 1;

    localparam logic [BCW-1:0] BC_LAST = BCW'(MAXB - 1);
    localparam logic [BCW-1:0] Y_C     = BCW'(Y);
    localparam logic [BCW-1:0] T_C     = BCW'(T);
    localparam logic [WCW-1:0] ND_C    = WCW'(ND);
    localparam logic [WCW-1:0] LAST_C  = WCW'(NW - 1);

    state_t         state, state_nxt;
    logic           r1;
    logic           ready_prev;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [WCW-1:0] word_cnt, word_cnt_nxt;
    logic [Y-1:0]   data_buf, data_buf_nxt;
    logic [T-1:0]   tag_buf, tag_buf_nxt;
    logic [W-1:0]   out_data_nxt;
    logic           is_tag_nxt;
    logic           last_nxt;

    // Zero-pads each buffer to a whole number of words before selecting word k.
    function automatic logic [W-1:0] word_mux(input logic [WCW-1:0] k,
                                              input logic [Y-1:0]   dbuf,
                                              input logic [T-1:0]   tbuf);
        logic [ND*W-1:0] dpad;
        logic [NT*W-1:0] tpad;
        dpad = '0;
        tpad = '0;
        dpad[Y-1:0] = dbuf;
        tpad[T-1:0] = tbuf;
        if (k < ND_C) begin
            return dpad[int'(k)*W +: W];
        end
        return tpad[(int'(k) - ND)*W +: W];
    endfunction

    assign out_valid = (state == S_DRAIN);
    assign busy      = (state == S_CAPTURE) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        data_buf_nxt = data_buf;
        tag_buf_nxt  = tag_buf;
        out_data_nxt = out_data;
        is_tag_nxt   = out_is_tag;
        last_nxt     = out_last;

        if (clear) begin
            state_nxt    = S_IDLE;
            bit_cnt_nxt  = '0;
            word_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready_si && !ready_prev) begin
                        state_nxt   = S_CAPTURE;
                        bit_cnt_nxt = '0;
                    end
                end
                S_CAPTURE: begin
                    if (r1) begin
                        if (bit_cnt < Y_C) data_buf_nxt[bit_cnt[DIW-1:0]] = data_si;
                        if (bit_cnt < T_C) tag_buf_nxt[bit_cnt[TIW-1:0]] = tag_si;
                        bit_cnt_nxt = bit_cnt + BCW'(1);
                        // Word 0 is muxed from the post-sample buffers so the final bit is included.
                        if (bit_cnt == BC_LAST) begin
                            state_nxt    = S_DRAIN;
                            word_cnt_nxt = '0;
                            out_data_nxt = word_mux('0, data_buf_nxt, tag_buf_nxt);
                            is_tag_nxt   = (ND == 0);
                            last_nxt     = (NW == 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        word_cnt_nxt = word_cnt + WCW'(1);
                        if (word_cnt == LAST_C) begin
                            state_nxt = S_DONE;
                        end else begin
                            out_data_nxt = word_mux(word_cnt_nxt, data_buf, tag_buf);
                            is_tag_nxt   = (word_cnt_nxt >= ND_C);
                            last_nxt     = (word_cnt_nxt == LAST_C);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ready_prev tracks the line even in reset, so a level held high across reset is not an edge.
    always_ff @(posedge clk) begin
        ready_prev <= ready_si;
        if (rst) begin
            state      <= S_IDLE;
            r1         <= 1'b0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            out_data   <= '0;
            out_is_tag <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            state      <= state_nxt;
            r1         <= ready_si;
            bit_cnt    <= bit_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
            out_data   <= out_data_nxt;
            out_is_tag <= is_tag_nxt;
            out_last   <= last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        data_buf <= data_buf_nxt;
        tag_buf  <= tag_buf_nxt;
    end

endmodule

// File: tb/tb_ascon_result_deserializer.sv
// Scoreboard bench for ascon_result_deserializer: serial messages in, expected
// words queued at drive time and compared as the DUT hands them out.
module tb_ascon_result_deserializer;

    localparam int Y  = 200;
    localparam int T  = 128;
    localparam int W  = 32;
    localparam int ND = 7;
    localparam int NW = 11;

    typedef struct packed {
        logic [W-1:0] data;
        logic         is_tag;
        logic         last;
    } word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready_si;
    logic         data_si;
    logic         tag_si;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_is_tag;
    logic         out_last;
    logic         busy;
    logic         done;

    word_t        sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] rx_data[16];
    logic         rx_tag[16];
    logic         rx_last[16];
    int           rx_cnt = 0;
    logic         bp_en = 1'b0;
    int           bp_left = 0;
    logic [Y-1:0] d_pat;
    logic [Y-1:0] d_ones;
    logic [T-1:0] t_pat;
    logic [T-1:0] t_zero;

    always #5 clk = ~clk;

    ascon_result_deserializer #(.Y(Y), .T(T), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready_si   (ready_si),
        .data_si    (data_si),
        .tag_si     (tag_si),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_is_tag (out_is_tag),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [Y-1:0] d, input logic [T-1:0] t);
        for (int k = 0; k < NW; k++) begin
            word_t e;
            e.data = '0;
            for (int b = 0; b < W; b++) begin
                int idx;
                if (k < ND) begin
                    idx = k * W + b;
                    if (idx < Y) e.data[b] = d[idx];
                end else begin
                    idx = (k - ND) * W + b;
                    if (idx < T) e.data[b] = t[idx];
                end
            end
            e.is_tag = (k >= ND);
            e.last   = (k == NW - 1);
            sb.push_back(e);
        end
    endtask

    // Launch one bit per ready_si-high cycle; each bit sits on the line the cycle after.
    task automatic send(input logic [Y-1:0] d, input logic [T-1:0] t,
                        input int stall_after, input int abort_at);
        int launched = 0;
        int last = -1;
        int cur;
        int stall = 0;
        if (abort_at < 0) push_expected(d, t);
        while (launched < Y || last >= 0) begin
            if (abort_at >= 0 && last == abort_at) begin
                clear    = 1'b1;
                ready_si = 1'b0;
                data_si  = 1'b0;
                tag_si   = 1'b0;
                step();
                clear = 1'b0;
                return;
            end
            data_si = (last >= 0) ? d[last] : 1'b0;
            tag_si  = (last >= 0 && last < T) ? t[last] : 1'b0;
            if (launched < Y && stall == 0) begin
                ready_si = 1'b1;
                cur = launched;
                launched++;
                if (cur == stall_after) stall = 3;
            end else begin
                ready_si = 1'b0;
                cur = -1;
                if (stall > 0) stall--;
            end
            last = cur;
            step();
        end
        ready_si = 1'b0;
        data_si  = 1'b0;
        tag_si   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 500) begin
            step();
            n++;
        end
        chk("done_within_budget", done, 1);
        chk("busy_after_done", busy, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        chk("done_cleared", done, 0);
    endtask

    task automatic check_nominal(input string name);
        chk({name, "_count"}, rx_cnt, NW);
        chk({name, "_w0"}, rx_data[0], 32'h49249249);
        chk({name, "_w2"}, rx_data[2], 32'h24924924);
        chk({name, "_w6"}, rx_data[6], 32'h00000049);
        chk({name, "_w6_tag"}, rx_tag[6], 0);
        chk({name, "_w7"}, rx_data[7], 32'h0F1E2D3C);
        chk({name, "_w7_tag"}, rx_tag[7], 1);
        chk({name, "_w10"}, rx_data[10], 32'hDEADBEEF);
        chk({name, "_w10_last"}, rx_last[10], 1);
        chk({name, "_w9_last"}, rx_last[9], 0);
    endtask

    // Sink: drives out_ready at the falling edge and scores words that will transfer.
    initial begin
        word_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_en && bp_left > 0 && rx_cnt == 2 && (out_valid || bp_left < 5)) begin
                chk("bp_valid_held", out_valid, 1);
                chk("bp_data_held", out_data, 32'h24924924);
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_is_tag", out_is_tag, e.is_tag);
                    chk("word_last", out_last, e.last);
                end
                if (rx_cnt < 16) begin
                    rx_data[rx_cnt] = out_data;
                    rx_tag[rx_cnt]  = out_is_tag;
                    rx_last[rx_cnt] = out_last;
                end
                rx_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < Y; j++) d_pat[j] = (j % 3 == 0);
        d_ones = '1;
        t_pat  = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
        t_zero = '0;

        rst = 1'b1; ready_si = 1'b1; data_si = 1'b0; tag_si = 1'b0; clear = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        repeat (5) step();
        chk("no_capture_after_reset", busy, 0);
        chk("no_valid_after_reset", out_valid, 0);
        ready_si = 1'b0;
        repeat (2) step();

        // Nominal message
        rx_cnt = 0;
        send(d_pat, t_pat, -1, -1);
        wait_done();
        check_nominal("nom");
        pulse_clear();

        // Backpressure on word 2
        bp_en = 1'b1; bp_left = 5; rx_cnt = 0;
        send(d_pat, t_pat, -1, -1);
        wait_done();
        chk("bp_exercised", bp_left, 0);
        bp_en = 1'b0;
        check_nominal("bp");
        pulse_clear();

        // Serial stall after bit 50
        rx_cnt = 0;
        send(d_pat, t_pat, 50, -1);
        wait_done();
        check_nominal("stall");
        pulse_clear();

        // Abort at bit 100, then an all-ones payload with a zero tag
        rx_cnt = 0;
        send(d_pat, t_pat, -1, 100);
        chk("abort_idle", busy, 0);
        chk("abort_no_valid", out_valid, 0);
        repeat (2) step();
        chk("abort_no_words", rx_cnt, 0);
        send(d_ones, t_zero, -1, -1);
        wait_done();
        chk("ones_count", rx_cnt, NW);
        for (int k = 0; k < 6; k++) chk("ones_word", rx_data[k], 32'hFFFFFFFF);
        chk("ones_w6", rx_data[6], 32'h000000FF);
        for (int k = 7; k < NW; k++) chk("ones_tag_word", rx_data[k], 0);

        // Done holds while ready_si stays high; only clear plus a new edge restarts
        ready_si = 1'b1;
        repeat (8) begin
            step();
            chk("hold_no_valid", out_valid, 0);
            chk("hold_done", done, 1);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("hold_cleared", done, 0);
        repeat (3) begin
            step();
            chk("hold_no_edge", busy, 0);
        end
        ready_si = 1'b0;
        step();
        rx_cnt = 0;
        send(d_pat, t_pat, -1, -1);
        wait_done();
        check_nominal("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
